mem_image_reader: RTL

MEM_IMAGE_READER -- requirements
Module: mem_image_reader

---
 rtl/mem_image_reader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_image_reader.sv
// mem_image_reader
//   Streams a burst of consecutive words out of a fixed-latency read-only
//   memory. A start pulse in IDLE captures base_addr/num_words. Reads are
//   issued at consecutive (wrapping) addresses, and the returned data is
//   buffered in a small FIFO. It is then presented on a valid/ready stream
//   that has a final-word flag.
//
//   Parameters
//     ADDR_W      memory address / burst length width
//     DATA_W      word width
//     RD_LATENCY  cycles from mem_ren to valid mem_rdata (1..3)
//
//   Ports
//     clk, rst               clock, synchronous active-high reset
//     start                  launch a burst (sampled only while idle)
//     base_addr, num_words   first address and word count of the burst
//     mem_ren, mem_addr      memory read strobe and address
//     mem_rdata              memory read data, RD_LATENCY cycles after mem_ren
//     out_valid, out_ready   downstream handshake
//     out_data, out_last     stream word and final-word flag
//     busy, done             burst in progress / one-cycle completion pulse
//     cksum                  (only with MEM_READER_CKSUM_EN) modulo-2^DATA_W
//                            sum of the words transferred in the last burst
//
//   Optional feature macro: MEM_READER_CKSUM_EN
module mem_image_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef MEM_READER_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum
`endif
);

  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_t              state;
  logic [ADDR_W-1:0]   issue_left;     // reads still to issue after the one on mem_ren
  logic [ADDR_W-1:0]   out_left;       // words still to hand downstream
  logic [CNT_W-1:0]    pending;        // current read + in-flight reads + FIFO occupancy
  logic [CNT_W-1:0]    fifo_cnt;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [RD_LATENCY-1:0] rd_vld_p;     // rd_vld_p[k]: a read issued k+1 cycles ago
  logic [DATA_W-1:0]   fifo_q [DEPTH];

  logic                pop;
  logic                push;
  logic                start_ok;
  logic                can_issue;
  logic [CNT_W-1:0]    pend_after_pop;

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = fifo_q[rd_ptr];
  assign out_last  = out_valid && (out_left == ADDR_W'(1));
  assign busy      = (state != IDLE);

  assign pop      = out_valid & out_ready;
  assign push     = rd_vld_p[RD_LATENCY-1];
  assign start_ok = (state == IDLE) && start;

  // A read may be committed only if, after this cycle's pop, there is still
  // a FIFO slot that no earlier read has claimed.
  assign pend_after_pop = pending - CNT_W'(pop);
  assign can_issue      = (state == READ) && (issue_left != '0) &&
                          (pend_after_pop < CNT_W'(DEPTH));

  // ---- control: FSM, read issue, in-flight tracking, FIFO pointers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_ren    <= 1'b0;
      done       <= 1'b0;
      issue_left <= '0;
      out_left   <= '0;
      pending    <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_vld_p   <= '0;
    end else begin
      done <= 1'b0;

      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
      end
      rd_vld_p[0] <= mem_ren;

      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        out_left <= out_left - ADDR_W'(1);
      end
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            if (num_words == '0) begin
              done <= 1'b1;
            end else begin
              state      <= READ;
              mem_ren    <= 1'b1;
              issue_left <= num_words - ADDR_W'(1);
              out_left   <= num_words;
              pending    <= CNT_W'(1);
            end
          end
        end
        READ: begin
          mem_ren <= can_issue;
          pending <= pend_after_pop + CNT_W'(can_issue);
          if (can_issue) begin
            issue_left <= issue_left - ADDR_W'(1);
          end
          if (mem_ren && (issue_left == '0)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          pending <= pend_after_pop;
          if (pop && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- data: read address and FIFO storage ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= mem_rdata;
    end
    if (start_ok) begin
      mem_addr <= base_addr;
    end else if (mem_ren) begin
      mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

`ifdef MEM_READER_CKSUM_EN
  // ---- checksum of transferred words ----
  always_ff @(posedge clk) begin
    if (start_ok) begin
      cksum <= '0;
    end else if (pop) begin
      cksum <= cksum + out_data;
    end
  end
`endif

endmodule
